// File: rtl/pman_btn_cond.sv
// Button conditioner for the Pac-Man movement controller: 2-FF sync, per-button
// debounce and a sticky press latch so no debounced press is missed by frame_tick.
module pman_btn_cond #(
    parameter int N_BTN        = 5,
    parameter int DEBOUNCE_CYC = 1_485_000,
    parameter int CNT_W        = 21
) (
    input  logic             clk_pix,
    input  logic             rstn,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             frame_tick,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_rise,
    output logic [N_BTN-1:0] btn_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [N_BTN-1:0] s1;
    logic [N_BTN-1:0] s2;
    logic [N_BTN-1:0] level_nxt;
    logic [N_BTN-1:0] rise_nxt;
    logic [N_BTN-1:0] press_pend;
    logic [CNT_W-1:0] cnt     [N_BTN];
    logic [CNT_W-1:0] cnt_nxt [N_BTN];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk_pix or negedge rstn) begin
        if (!rstn) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    // NOTE: every combinational output gets a default before any branch,
    // otherwise an unassigned path infers a latch.
    always_comb begin
        level_nxt = btn_level;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_nxt[i] = '0;
            if (s2[i] != btn_level[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    level_nxt[i] = s2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
        rise_nxt = level_nxt & ~btn_level;
    end

    // NOTE: the counter array is small and must restart from zero after a
    // mid-count reset, so it is reset like any other register.
    always_ff @(posedge clk_pix or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_BTN; i++) begin
                cnt[i] <= '0;
            end
            btn_level  <= '0;
            btn_rise   <= '0;
            press_pend <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            btn_level  <= level_nxt;
            btn_rise   <= rise_nxt;
            // A new rise beats a coincident frame_tick.
            press_pend <= rise_nxt | (press_pend & ~{N_BTN{frame_tick}});
        end
    end

    assign btn_pulse = btn_level | press_pend;

endmodule
